// File: rtl/lru_lamp_tracker_if.sv
// lru_lamp_tracker_if: raw button levels in, lamp levels out for the LRU lamp tracker.
interface lru_lamp_tracker_if;
  logic b1, b2, b3, b4, b5;
  logic l1, l2, l3, l4, l5;
  modport master (output b1, b2, b3, b4, b5, input l1, l2, l3, l4, l5);
  modport slave (input b1, b2, b3, b4, b5, output l1, l2, l3, l4, l5);
endinterface

// File: rtl/lru_lamp_tracker.sv
// lru_lamp_tracker: five-button LRU tracker lighting at most MAX_ON lamps, cleared by a long all-button hold.
module lru_lamp_tracker #(
    parameter int MAX_ON = 4,
    parameter int CLEAR_HOLD = 99_999_990,
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    lru_lamp_tracker_if.slave bus
);
    logic [4:0] btn, lit_n;
    logic [4:0] lit = '0;
    logic [4:0][2:0] rank = '0;
    logic [4:0][2:0] rank_n;
    logic [CNT_W-1:0] cnt = '0;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0] idx, n_lit, ref_rank;
    logic one, hold, clear;
    always_comb begin
        btn = {bus.b5, bus.b4, bus.b3, bus.b2, bus.b1};
        one = $onehot(btn);
        hold = &btn;
        idx = '0;
        n_lit = '0;
        for (int i = 0; i < 5; i++) begin
            if (btn[i]) idx = 3'(i);
            n_lit = n_lit + 3'(lit[i]);
        end
        // an unlit target ranks just past every lit slot, so all lit slots age by one
        ref_rank = lit[idx] ? rank[idx] : n_lit;
        clear = hold && cnt >= CNT_W'(CLEAR_HOLD - 1);
        cnt_n = hold ? ((cnt == CNT_W'(CLEAR_HOLD)) ? cnt : cnt + 1'b1) : '0;
        lit_n = lit;
        rank_n = rank;
        if (clear) begin
            lit_n = '0;
            rank_n = '0;
        end else if (one) begin
            for (int i = 0; i < 5; i++) begin
                if (3'(i) == idx) begin
                    lit_n[i] = 1'b1;
                    rank_n[i] = '0;
                end else if (lit[i] && rank[i] < ref_rank) begin
                    rank_n[i] = rank[i] + 3'd1;
                    if (rank_n[i] == 3'(MAX_ON)) begin
                        lit_n[i] = 1'b0;
                        rank_n[i] = '0;
                    end
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lit <= '0;
            rank <= '0;
            cnt <= '0;
        end else begin
            lit <= lit_n;
            rank <= rank_n;
            cnt <= cnt_n;
        end
    end
    assign bus.l1 = lit[0];
    assign bus.l2 = lit[1];
    assign bus.l3 = lit[2];
    assign bus.l4 = lit[3];
    assign bus.l5 = lit[4];
endmodule

// File: tb/tb_lru_lamp_tracker.sv
// tb_lru_lamp_tracker: directed and random stimulus checked against a recency-queue model.
module tb_lru_lamp_tracker;
    localparam int MAX_ON = 4;
    localparam int CH = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    int q[$];
    int hold_cnt = 0;
    logic [4:0] lamps;
    lru_lamp_tracker_if bus ();
    lru_lamp_tracker #(.MAX_ON(MAX_ON), .CLEAR_HOLD(CH), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign lamps = {bus.l5, bus.l4, bus.l3, bus.l2, bus.l1};
    initial {bus.b5, bus.b4, bus.b3, bus.b2, bus.b1} = 5'b0;
    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: lamps l5..l1 got %b expected %b", tag, got, exp);
        end
    endtask
    // model: q holds lit slots front = most recent
    function automatic void model_step(input logic [4:0] b);
        int idx;
        if (&b) begin
            if (hold_cnt < CH) hold_cnt++;
            if (hold_cnt == CH) q.delete();
        end else begin
            hold_cnt = 0;
            if ($onehot(b)) begin
                idx = 0;
                for (int i = 0; i < 5; i++) if (b[i]) idx = i;
                for (int i = q.size() - 1; i >= 0; i--) if (q[i] == idx) q.delete(i);
                if (q.size() == MAX_ON) void'(q.pop_back());
                q.push_front(idx);
            end
        end
    endfunction
    function automatic logic [4:0] model_lamps();
        logic [4:0] m = '0;
        foreach (q[i]) m[q[i]] = 1'b1;
        return m;
    endfunction
    task automatic step(input logic [4:0] b, input string tag);
        @(negedge clk);
        {bus.b5, bus.b4, bus.b3, bus.b2, bus.b1} = b;
        @(posedge clk);
        model_step(b);
        #2 check(tag, lamps, model_lamps());
    endtask
    task automatic do_reset();
        @(negedge clk);
        {bus.b5, bus.b4, bus.b3, bus.b2, bus.b1} = 5'b0;
        #1 rst = 1'b1;
        q.delete();
        hold_cnt = 0;
        #1 check("rst_async", lamps, 5'b0);
        @(negedge clk) rst = 1'b0;
    endtask
    initial begin
        int r, len;
        logic [4:0] pat;
        repeat (CH + 8) step(5'h1f, "por_hold");
        step(5'b00001, "por_b1");
        check("por_b1_lit", lamps, 5'b00001);
        step(5'b00010, "por_b2");
        step(5'b00100, "por_b3");
        step(5'b01000, "por_b4");
        check("por_b4_lit", lamps, 5'b01111);
        step(5'b10000, "por_b5");
        check("evict_l1", lamps, 5'b11110);
        do_reset();
        repeat (3) begin
            step(5'b00001, "b1_hold");
            check("b1_hold_lit", lamps, 5'b00001);
        end
        step(5'b00010, "b2");
        check("b2_lit", lamps, 5'b00011);
        do_reset();
        for (int i = 0; i < 4; i++) step(5'b1 << i, "fill");
        step(5'b00001, "touch_b1");
        step(5'b10000, "b5_evict");
        check("evict_l2", lamps, 5'b11101);
        do_reset();
        for (int i = 0; i < 4; i++) step(5'b1 << i, "fill");
        repeat (3) step(5'b00101, "multi");
        repeat (10) step(5'b00000, "idle");
        check("multi_idle", lamps, 5'b01111);
        do_reset();
        step(5'b00001, "pre1");
        step(5'b00010, "pre2");
        repeat (CH - 1) step(5'h1f, "short_hold");
        check("short_hold_kept", lamps, 5'b00011);
        step(5'b00000, "release");
        check("release_kept", lamps, 5'b00011);
        repeat (CH - 1) step(5'h1f, "full_hold");
        check("before_clear", lamps, 5'b00011);
        step(5'h1f, "clear_edge");
        check("clear_edge_dark", lamps, 5'b00000);
        repeat (4) step(5'h1f, "held_after_clear");
        step(5'b00000, "release2");
        for (int i = 0; i < 4; i++) step(5'b1 << i, "fill");
        do_reset();
        step(5'b00100, "after_rst_b3");
        check("after_rst_b3_lit", lamps, 5'b00100);
        repeat (80) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                pat = 5'b1 << $urandom_range(0, 4);
                len = $urandom_range(1, 3);
            end else if (r < 8) begin
                pat = 5'($urandom_range(0, 31));
                len = $urandom_range(1, 2);
            end else if (r == 8) begin
                pat = 5'h1f;
                len = $urandom_range(CH - 3, CH + 3);
            end else begin
                pat = 5'b0;
                len = $urandom_range(1, 3);
            end
            repeat (len) step(pat, "rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lru_lamp_tracker.md
Name: lru_lamp_tracker

Overview:
- Five-button / five-lamp least-recently-used tracker.
- A press of button bN marks slot N as most-recently used and lights lamp lN.
- At most MAX_ON lamps are lit at once. Lighting a new lamp when the limit is reached extinguishes the least-recently-used lit lamp.
- Holding all five buttons long enough clears the tracker. The block is a standalone UI/demo controller driven by raw button levels.

Parameters:
- MAX_ON, 4, maximum number of simultaneously lit lamps (1..5).
- CLEAR_HOLD, 99_999_990, consecutive cycles all five buttons must be high to clear the tracker (≥1).
- CNT_W, 32, width of the clear-hold counter; must hold CLEAR_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- b1  input  1  button 1 level (high = pressed).
- b2  input  1  button 2 level.
- b3  input  1  button 3 level.
- b4  input  1  button 4 level.
- b5  input  1  button 5 level.
- l1  output  1  lamp 1 (high = lit).
- l2  output  1  lamp 2.
- l3  output  1  lamp 3.
- l4  output  1  lamp 4.
- l5  output  1  lamp 5.

Behaviour:
- One clock; reset is asynchronous and active-high. rst is active-high and asynchronous: it immediately forces all lamps off, the recency history empty and the hold counter to 0.
- All state registers also carry power-on initial values equal to their reset values. The block therefore works if rst is never asserted.
- Outputs are registered: l1..l5 directly reflect the lit flags. A button sampled on rising edge k affects the lamps after edge k (one-cycle latency, visible before the next edge).
- State per slot: a lit flag and a recency rank among lit slots (0 = most recent). Unlit slots carry no rank.
- Input classification each cycle:
  - exactly one button high = access to that slot;
  - zero buttons high, or 2..4 high = idle, no state change;
  - all five high = clear-hold cycle.
- Access to an already-lit slot: that slot becomes rank 0. Lit slots that were more recent shift down one rank. Lamp pattern is unchanged.
- Access to an unlit slot while fewer than MAX_ON slots are lit: the slot lights at rank 0 and all other lit ranks increment.
- Access to an unlit slot while MAX_ON slots are lit: the slot with the highest rank (LRU) goes dark, the new slot lights at rank 0, and the other ranks increment. The lit count stays MAX_ON. Both changes happen on the same edge.
- Holding the same single button across many cycles is idempotent after the first cycle.
- Clear hold: the counter increments on each all-five-high cycle and resets to 0 on any other cycle. When it reaches CLEAR_HOLD, all lamps turn off and the history is emptied on that edge. The counter saturates, so the tracker stays cleared while the buttons remain held. No lamp/recency change happens during hold cycles before the clear.
- No debouncing or edge detection; buttons are treated as synchronous levels.
- Reset mid-operation discards all history; the next access lights a single lamp.

Test Plan:
- Reset, then b1 alone for 3 cycles -> l1..l5 = 1,0,0,0,0 after each cycle; then b2 alone -> 1,1,0,0,0.
- Bench without ever asserting rst: all five held for CLEAR_HOLD+8 cycles, then b1 -> 1,0,0,0,0. Then b2, b3, b4 in turn -> 1,1,0,0,0 / 1,1,1,0,0 / 1,1,1,1,0. Then b5 -> 0,1,1,1,1 (lamp 1 evicted).
- After reset: press b1,b2,b3,b4, then b1 again, then b5 -> 1,0,1,1,1 (lamp 2 is LRU).
- Lamps 1..4 lit; hold b1+b3 together, then all released for 10 cycles -> lamps unchanged 1,1,1,1,0.
- All five held for CLEAR_HOLD-1 cycles then released, with lamps 1,1,0,0,0 -> unchanged. Holding for CLEAR_HOLD cycles -> 0,0,0,0,0 on the CLEAR_HOLD-th edge. Use a small CLEAR_HOLD override, e.g. 16.
- Lamps 1..4 lit; assert rst asynchronously between edges -> all lamps 0 immediately. After release, b3 -> 0,0,1,0,0.
